dds_reset_sequencer: RTL and testbench

PLL lock supervisor and staged reset sequencer for the DDS function generator. It drives the PLL reset, qualifies `PllLocked`, and releases the DDS datapath resets in a fixed order once lock is stable:

- stage 0: phase accumulator
- stage 1: waveform LUT / shaping
- stage 2: DAC output interface

It also handles lock timeout, bounded retry, lock loss and software-requested resets. It sits between the board-level reset/PLL and every DDS datapath reset input.

---
 rtl/dds_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 tb/tb_dds_reset_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : dds_reset_sequencer
//  Brief    : PLL lock supervisor and staged reset sequencer for the DDS
//             function generator. Holds the PLL in reset, qualifies the
//             synchronized lock, then releases the datapath stage resets
//             in order 0 -> 1 -> 2 (accumulator, LUT/shaping, DAC IF).
//             Handles lock timeout with bounded retry, lock loss and
//             software restart.
//  Options  : DDS_RSTSEQ_LOCKLOSS_RECOVER_EN - when defined, lock loss in
//             RELEASE/RUN retries the PLL (while retries remain) instead
//             of going straight to FAULT.
//  Revision : 1.0 - initial release
// ============================================================================
module dds_reset_sequencer #(
    parameter int PLL_RST_CYC     = 16,
    parameter int LOCK_TIMEOUT    = 4096,
    parameter int LOCK_STABLE_CYC = 64,
    parameter int STAGE_GAP       = 8,
    parameter int MAX_RETRY       = 3
) (
    input  logic       CLK,
    input  logic       RESETn,
    input  logic       PllLocked,
    input  logic       SoftRst,
    output logic       PllRESETn,
    output logic [2:0] Stage_RESETn,
    output logic       Ready,
    output logic       Fault,
    output logic [3:0] RetryCnt
);

    // ------------------------------------------------------------------
    // Counter widths and terminal values
    // ------------------------------------------------------------------
    localparam int c_RST_W    = $clog2(PLL_RST_CYC + 1);
    localparam int c_TO_W     = $clog2(LOCK_TIMEOUT + 1);
    localparam int c_STABLE_W = $clog2(LOCK_STABLE_CYC + 1);
    localparam int c_GAP_W    = $clog2(STAGE_GAP + 1);

    localparam logic [c_RST_W-1:0]    c_RST_CYC   = c_RST_W'(PLL_RST_CYC);
    localparam logic [c_TO_W-1:0]     c_TIMEOUT   = c_TO_W'(LOCK_TIMEOUT);
    localparam logic [c_STABLE_W-1:0] c_STABLE    = c_STABLE_W'(LOCK_STABLE_CYC);
    localparam logic [c_GAP_W-1:0]    c_GAP       = c_GAP_W'(STAGE_GAP);
    localparam logic [3:0]            c_MAX_RETRY = 4'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic                    r_lockMeta;
    logic                    r_lockSync;
    logic [c_RST_W-1:0]      r_rstCnt;
    logic [c_TO_W-1:0]       r_timeoutCnt;
    logic [c_STABLE_W-1:0]   r_stableCnt;
    logic [c_GAP_W-1:0]      r_gapCnt;
    logic [3:0]              r_retryCnt;
    logic                    r_pllRstN;
    logic [2:0]              r_stageRstN;
    logic                    r_ready;
    logic                    r_fault;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t                  w_stateNext;
    logic [c_RST_W-1:0]      w_rstCnt;
    logic [c_TO_W-1:0]       w_timeoutCnt;
    logic [c_STABLE_W-1:0]   w_stableCnt;
    logic [c_GAP_W-1:0]      w_gapCnt;
    logic [3:0]              w_retryCnt;
    logic [2:0]              w_stageRstN;
    logic                    w_pllRstN;
    logic [2:0]              w_stageOut;
    logic                    w_ready;
    logic                    w_fault;
    logic                    w_lossRetry;

    // Saturating increments: counters park at their terminal value
    logic [c_RST_W-1:0]      w_rstInc;
    logic [c_TO_W-1:0]       w_timeoutInc;
    logic [c_STABLE_W-1:0]   w_stableInc;
    logic [c_GAP_W-1:0]      w_gapInc;

    assign w_rstInc     = (r_rstCnt     == c_RST_CYC) ? r_rstCnt     : r_rstCnt     + 1'b1;
    assign w_timeoutInc = (r_timeoutCnt == c_TIMEOUT) ? r_timeoutCnt : r_timeoutCnt + 1'b1;
    assign w_stableInc  = (r_stableCnt  == c_STABLE)  ? r_stableCnt  : r_stableCnt  + 1'b1;
    assign w_gapInc     = (r_gapCnt     == c_GAP)     ? r_gapCnt     : r_gapCnt     + 1'b1;

    // Lock loss either retries the PLL (recover build) or always faults
`ifdef DDS_RSTSEQ_LOCKLOSS_RECOVER_EN
    assign w_lossRetry = (r_retryCnt < c_MAX_RETRY);
`else
    assign w_lossRetry = 1'b0;
`endif

    // Lock synchronizer; held clear while the PLL is in reset so only lock
    // reported after PllRESETn deasserts can count toward qualification.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_lockMeta <= 1'b0;
            r_lockSync <= 1'b0;
        end else begin
            r_lockMeta <= r_pllRstN & PllLocked;
            r_lockSync <= r_pllRstN & r_lockMeta;
        end
    end

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state      <= ST_PLL_RST;
            r_rstCnt     <= '0;
            r_timeoutCnt <= '0;
            r_stableCnt  <= '0;
            r_gapCnt     <= '0;
            r_retryCnt   <= '0;
            r_pllRstN    <= 1'b0;
            r_stageRstN  <= 3'b000;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_stateNext;
            r_rstCnt     <= w_rstCnt;
            r_timeoutCnt <= w_timeoutCnt;
            r_stableCnt  <= w_stableCnt;
            r_gapCnt     <= w_gapCnt;
            r_retryCnt   <= w_retryCnt;
            r_pllRstN    <= w_pllRstN;
            r_stageRstN  <= w_stageOut;
            r_ready      <= w_ready;
            r_fault      <= w_fault;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        w_stateNext  = r_state;
        w_rstCnt     = r_rstCnt;
        w_timeoutCnt = r_timeoutCnt;
        w_stableCnt  = r_stableCnt;
        w_gapCnt     = r_gapCnt;
        w_retryCnt   = r_retryCnt;
        w_stageRstN  = r_stageRstN;

        case (r_state)
            ST_PLL_RST: begin
                w_rstCnt = w_rstInc;
                if (w_rstInc == c_RST_CYC) begin
                    w_stateNext  = ST_WAIT_LOCK;
                    w_timeoutCnt = '0;
                    w_stableCnt  = '0;
                end
            end

            ST_WAIT_LOCK: begin
                w_timeoutCnt = w_timeoutInc;
                w_stableCnt  = r_lockSync ? w_stableInc : '0;
                // Qualification is tested first so it wins a same-cycle timeout
                if (r_lockSync && (w_stableInc == c_STABLE)) begin
                    w_stateNext = ST_RELEASE;
                    w_gapCnt    = '0;
                    w_stageRstN = 3'b001;
                end else if (w_timeoutInc == c_TIMEOUT) begin
                    if (r_retryCnt < c_MAX_RETRY) begin
                        w_retryCnt  = r_retryCnt + 4'd1;
                        w_stateNext = ST_PLL_RST;
                        w_rstCnt    = '0;
                    end else begin
                        w_stateNext = ST_FAULT;
                    end
                end
            end

            ST_RELEASE: begin
                if (!r_lockSync) begin
                    if (w_lossRetry) begin
                        w_retryCnt  = r_retryCnt + 4'd1;
                        w_stateNext = ST_PLL_RST;
                        w_rstCnt    = '0;
                    end else begin
                        w_stateNext = ST_FAULT;
                    end
                end else if (r_stageRstN[2]) begin
                    w_stateNext = ST_RUN;
                end else begin
                    w_gapCnt = w_gapInc;
                    if (w_gapInc == c_GAP) begin
                        w_gapCnt    = '0;
                        w_stageRstN = {r_stageRstN[1:0], 1'b1};
                    end
                end
            end

            ST_RUN: begin
                if (!r_lockSync) begin
                    if (w_lossRetry) begin
                        w_retryCnt  = r_retryCnt + 4'd1;
                        w_stateNext = ST_PLL_RST;
                        w_rstCnt    = '0;
                    end else begin
                        w_stateNext = ST_FAULT;
                    end
                end
            end

            ST_FAULT: begin
                w_stateNext = ST_FAULT;
            end

            default: begin
                w_stateNext = ST_PLL_RST;
                w_rstCnt    = '0;
            end
        endcase

        // Software restart overrides every other transition
        if (SoftRst) begin
            w_stateNext  = ST_PLL_RST;
            w_rstCnt     = '0;
            w_timeoutCnt = '0;
            w_stableCnt  = '0;
            w_gapCnt     = '0;
            w_retryCnt   = '0;
            w_stageRstN  = 3'b000;
        end

        // Outputs follow the state being entered, so they change on the
        // same edge as the state register
        w_pllRstN  = (w_stateNext == ST_WAIT_LOCK) || (w_stateNext == ST_RELEASE) ||
                     (w_stateNext == ST_RUN);
        w_stageOut = ((w_stateNext == ST_RELEASE) || (w_stateNext == ST_RUN)) ?
                     w_stageRstN : 3'b000;
        w_ready    = (w_stateNext == ST_RUN);
        w_fault    = (w_stateNext == ST_FAULT);
    end

    assign PllRESETn    = r_pllRstN;
    assign Stage_RESETn = r_stageRstN;
    assign Ready        = r_ready;
    assign Fault        = r_fault;
    assign RetryCnt     = r_retryCnt;

endmodule
`default_nettype wire

// File: tb/tb_dds_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dds_reset_sequencer
//  Brief    : Self-checking bench for dds_reset_sequencer. Expected event
//             times come from a timeline model built on the sequencing
//             rules (reset length, sync latency, stable window, stage gap).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dds_reset_sequencer;

    localparam int P_RST    = 16;
    localparam int P_STABLE = 8;
    localparam int P_TO     = 64;
    localparam int P_GAP    = 4;
    localparam int P_RETRY  = 2;
    localparam int P_SYNC   = 2;
    localparam int P_NEVER  = 1000000;

    logic       CLK       = 1'b0;
    logic       RESETn    = 1'b0;
    logic       PllLocked = 1'b0;
    logic       SoftRst   = 1'b0;
    logic       PllRESETn;
    logic [2:0] Stage_RESETn;
    logic       Ready;
    logic       Fault;
    logic [3:0] RetryCnt;

    int nVec  = 0;
    int nFail = 0;
    int cyc   = 0;
    int tPll, tS0, tS1, tS2, tRdy;

    dds_reset_sequencer #(
        .PLL_RST_CYC    (P_RST),
        .LOCK_TIMEOUT   (P_TO),
        .LOCK_STABLE_CYC(P_STABLE),
        .STAGE_GAP      (P_GAP),
        .MAX_RETRY      (P_RETRY)
    ) u_dut (
        .CLK         (CLK),
        .RESETn      (RESETn),
        .PllLocked   (PllLocked),
        .SoftRst     (SoftRst),
        .PllRESETn   (PllRESETn),
        .Stage_RESETn(Stage_RESETn),
        .Ready       (Ready),
        .Fault       (Fault),
        .RetryCnt    (RetryCnt)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nVec++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: advance past the rising edge, outputs are settled at +1
    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    // Hold reset a few clocks, then release just after an edge (tick 0)
    task automatic doReset(input logic lockVal);
        RESETn    = 1'b0;
        SoftRst   = 1'b0;
        PllLocked = lockVal;
        repeat (3) tick();
        RESETn = 1'b1;
        cyc    = 0;
    endtask

    // Model: tick at which stage 0 releases. Lock only counts once the PLL
    // is out of reset; a glitch inside the stable window restarts it.
    function automatic int expRelease(input int lockOn, input int glitch);
        int start;
        start = (lockOn > P_RST) ? lockOn : P_RST;
        if (glitch >= start && glitch < start + P_STABLE)
            start = glitch + 1;
        return start + P_SYNC + P_STABLE;
    endfunction

    function automatic logic [2:0] expStages(input int rel, input int t);
        logic [2:0] s;
        for (int i = 0; i < 3; i++)
            s[i] = (t >= rel + i * P_GAP);
        return s;
    endfunction

    // Drive the lock pin per tick and record the first tick each output rises
    task automatic watchRise(input int lockOn, input int glitch, input int endTick);
        tPll = -1; tS0 = -1; tS1 = -1; tS2 = -1; tRdy = -1;
        while (cyc < endTick) begin
            PllLocked = (cyc >= lockOn) && (cyc != glitch);
            if (tPll < 0 && PllRESETn === 1'b1)       tPll = cyc;
            if (tS0  < 0 && Stage_RESETn[0] === 1'b1) tS0  = cyc;
            if (tS1  < 0 && Stage_RESETn[1] === 1'b1) tS1  = cyc;
            if (tS2  < 0 && Stage_RESETn[2] === 1'b1) tS2  = cyc;
            if (tRdy < 0 && Ready === 1'b1)           tRdy = cyc;
            tick();
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, "_pllrstn"}, PllRESETn, 0);
        check({tag, "_stage"},   Stage_RESETn, 0);
        check({tag, "_ready"},   Ready, 0);
        check({tag, "_fault"},   Fault, 0);
        check({tag, "_retry"},   RetryCnt, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int rel, lockOn, g, d, viol, runLen, faultTick;
        int pulses[$];
        int pulseRetry[$];

        // ---- reset state ----
        RESETn = 1'b0;
        repeat (3) tick();
        checkResetOutputs("reset");

        // ---- clean bring-up with lock already high ----
        doReset(1'b1);
        watchRise(0, -1, 45);
        rel = expRelease(0, -1);
        check("clean_pll_rise", tPll, P_RST);
        check("clean_stage0",   tS0, rel);
        check("clean_stage1",   tS1, rel + P_GAP);
        check("clean_stage2",   tS2, rel + 2 * P_GAP);
        check("clean_ready",    tRdy, P_RST + 2 + P_STABLE + 2 * P_GAP + 1);
        check("clean_retry",    RetryCnt, 0);
        check("clean_fault",    Fault, 0);

        // ---- lock arrives at a random time ----
        lockOn = $urandom_range(50, 0);
        doReset(lockOn == 0);
        watchRise(lockOn, -1, 75);
        rel = expRelease(lockOn, -1);
        check("latelock_stage0", tS0, rel);
        check("latelock_stage2", tS2, rel + 2 * P_GAP);
        check("latelock_ready",  tRdy, rel + 2 * P_GAP + 1);

        // ---- one-cycle lock glitch during qualification ----
        for (int r = 0; r < 2; r++) begin
            g = (r == 0) ? P_RST + 5 : P_RST + $urandom_range(6, 1);
            doReset(1'b1);
            watchRise(0, g, 60);
            rel = expRelease(0, g);
            check("glitch_stage0", tS0, rel);
            check("glitch_ready",  tRdy, rel + 2 * P_GAP + 1);
        end

        // ---- never locks: retries then sticky fault ----
        doReset(1'b0);
        faultTick = (P_RETRY + 1) * (P_RST + P_TO);
        runLen = 0;
        viol   = 0;
        while (cyc < faultTick) begin
            if (Fault === 1'b1) viol++;
            if (PllRESETn === 1'b0) begin
                if (runLen == 0) pulseRetry.push_back(int'(RetryCnt));
                runLen++;
            end else if (runLen > 0) begin
                pulses.push_back(runLen);
                runLen = 0;
            end
            tick();
        end
        check("nolock_pulse_count", pulses.size(), P_RETRY + 1);
        for (int i = 0; i < pulses.size(); i++) begin
            check($sformatf("nolock_pulse%0d_len", i), pulses[i], P_RST);
            check($sformatf("nolock_pulse%0d_retry", i), pulseRetry[i], i);
        end
        check("nolock_early_fault", viol, 0);
        check("nolock_fault",       Fault, 1);
        check("nolock_pllrstn",     PllRESETn, 0);
        viol = 0;
        for (int i = 0; i < 1000; i++) begin
            if (!(Fault === 1'b1 && PllRESETn === 1'b0 && Stage_RESETn === 3'b000 &&
                  Ready === 1'b0))
                viol++;
            tick();
        end
        check("fault_hold", viol, 0);

        // ---- SoftRst while in FAULT ----
        PllLocked = 1'b1;
        repeat ($urandom_range(5, 1)) tick();
        SoftRst = 1'b1;
        tick();
        SoftRst = 1'b0;
        checkResetOutputs("softrst_fault");
        cyc = 0;
        watchRise(0, -1, 45);
        check("softrst_fault_pll_rise", tPll, P_RST);
        check("softrst_fault_ready",    tRdy, expRelease(0, -1) + 2 * P_GAP + 1);

        // ---- SoftRst on the same edge as the final lock timeout ----
        doReset(1'b0);
        while (cyc < faultTick - 1) tick();
        check("softrst_to_pre_retry", RetryCnt, P_RETRY);
        SoftRst = 1'b1;
        tick();
        SoftRst = 1'b0;
        checkResetOutputs("softrst_to");
        cyc = 0;
        watchRise(P_NEVER, -1, 30);
        check("softrst_to_pll_rise", tPll, P_RST);

        // ---- lock loss in RUN and in RELEASE ----
        for (int r = 0; r < 2; r++) begin
            d = (r == 0) ? $urandom_range(60, 35) : $urandom_range(31, 24);
            rel = expRelease(0, -1);
            doReset(1'b1);
            watchRise(0, -1, d);
            PllLocked = 1'b0;
            tick();
            tick();
            check("loss_pre_stage", Stage_RESETn, expStages(rel, d + 2));
            check("loss_pre_ready", Ready, (d + 2 >= rel + 2 * P_GAP + 1));
            tick();
            check("loss_stage", Stage_RESETn, 0);
            check("loss_ready", Ready, 0);
            check("loss_pllrstn", PllRESETn, 0);
`ifdef DDS_RSTSEQ_LOCKLOSS_RECOVER_EN
            check("loss_retry", RetryCnt, 1);
            check("loss_fault", Fault, 0);
`else
            check("loss_retry", RetryCnt, 0);
            check("loss_fault", Fault, 1);
`endif
        end

        // ---- async reset in the middle of RELEASE ----
        rel = expRelease(0, -1);
        doReset(1'b1);
        watchRise(0, -1, rel + P_GAP + 1);
        check("async_pre_stage", Stage_RESETn, expStages(rel, rel + P_GAP + 1));
        #3;
        RESETn = 1'b0;
        #1;
        checkResetOutputs("async");

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
`default_nettype wire
